sram_skew_feeder: RTL and testbench

// - Downstream read sequencer for the 32-bit operand SRAM (4 packed signed int8 per word, 1-cycle registered read).
// - On start, streams num_words consecutive words from base_addr.
// - Splits each word into 4 byte lanes and skews lane i by i cycles.
// - Output is the diagonal wavefront for the 4-wide systolic array edge.

---
 rtl/sram_skew_feeder.sv | 142 ++++++++++++++
 tb/tb_sram_skew_feeder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_skew_feeder.sv
// Operand SRAM read sequencer: streams K words from base_addr and skews byte lane i by i cycles.
// Optional `FEEDER_STALL_EN` adds a stall input that freezes the whole feeder.
module sram_skew_feeder #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef FEEDER_STALL_EN
    input  logic                      stall,
`endif
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CNT_W-1:0]          num_words,
    output logic                      sram_csb,
    output logic [ADDR_W-1:0]         sram_raddr,
    input  logic [LANES*DATA_W-1:0]   sram_rdata,
    output logic [LANES*DATA_W-1:0]   lane_data,
    output logic [LANES-1:0]          lane_valid,
    output logic                      busy,
    output logic                      done
);

    localparam int DRN_W = $clog2(LANES + 1);
    // DRAIN covers the capture stage plus the deepest lane delay.
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(LANES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic                csb_q;
    logic [ADDR_W-1:0]   raddr_q;
    logic [CNT_W-1:0]    left_q;
    logic [DRN_W-1:0]    drain_q;
    logic                busy_q;
    logic                done_q;
    logic                rvalid_q;
    logic [LANES-1:0]    vld_q;
    logic                adv;

`ifdef FEEDER_STALL_EN
    assign adv = ~stall;
`else
    assign adv = 1'b1;
`endif

    // A stalled cycle must never issue a read, so csb is forced high combinationally.
    assign sram_csb   = csb_q | ~adv;
    assign sram_raddr = raddr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign lane_valid = vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            csb_q   <= 1'b1;
            raddr_q <= '0;
            left_q  <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (adv) begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            state_q <= S_READ;
                            csb_q   <= 1'b0;
                            raddr_q <= base_addr;
                            left_q  <= num_words;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    left_q <= left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) begin
                        state_q <= S_DRAIN;
                        csb_q   <= 1'b1;
                        drain_q <= '0;
                    end else begin
                        raddr_q <= raddr_q + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DRN_W'(1);
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // rdata is meaningful exactly one un-stalled cycle after a read was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            vld_q    <= '0;
        end else if (adv) begin
            rvalid_q <= ~csb_q;
            vld_q    <= {vld_q[LANES-2:0], rvalid_q};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Stage 0 is the capture register; lane gi reads stage gi.
            logic [DATA_W-1:0] sr_q [0:gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d <= gi; d++) sr_q[d] <= '0;
                end else if (adv) begin
                    sr_q[0] <= rvalid_q ? sram_rdata[(LANES-gi)*DATA_W-1 -: DATA_W] : '0;
                    for (int d = 1; d <= gi; d++) sr_q[d] <= sr_q[d-1];
                end
            end

            assign lane_data[gi*DATA_W +: DATA_W] = sr_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sram_skew_feeder.sv
// Directed bench for sram_skew_feeder: per-cycle vector tables plus reset and stall sequences.
module tb_sram_skew_feeder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [7:0]  num_words;
    logic        sram_csb;
    logic [9:0]  sram_raddr;
    logic [31:0] sram_rdata;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid;
    logic        busy;
    logic        done;
`ifdef FEEDER_STALL_EN
    logic        stall;
`endif

    int tests = 0;
    int fails = 0;
    int hi_addr_cnt = 0;
    int done_cnt = 0;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic        start;
        logic [9:0]  base;
        logic [7:0]  k;
        logic        stall;
        logic        e_csb;
        logic [9:0]  e_addr;
        logic [3:0]  e_v;
        logic [31:0] e_d;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    sram_skew_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef FEEDER_STALL_EN
        .stall      (stall),
`endif
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .sram_csb   (sram_csb),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_csb) sram_rdata <= mem[sram_raddr];
        if (!sram_csb && sram_raddr >= 10'd64) hi_addr_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic st, input int b, input int k, input logic sl,
                                input logic ecsb, input int ea, input logic [3:0] ev,
                                input logic [31:0] ed, input logic eb, input logic edn);
        vec_t v;
        v.start = st; v.base = 10'(b); v.k = 8'(k); v.stall = sl;
        v.e_csb = ecsb; v.e_addr = 10'(ea); v.e_v = ev; v.e_d = ed;
        v.e_busy = eb; v.e_done = edn;
        return v;
    endfunction

    function automatic vec_t idl(input logic st, input int b, input int k);
        return mk(st, b, k, 1'b0, 1'b1, 0, 4'h0, 32'h0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t ex(input logic ecsb, input int ea, input logic [3:0] ev,
                                input logic [31:0] ed, input logic eb, input logic edn);
        return mk(1'b0, 0, 0, 1'b0, ecsb, ea, ev, ed, eb, edn);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Entered #1 after a rising edge: drive this cycle's inputs, check outputs, advance one cycle.
    task automatic apply_vec(input string nm, input int idx, input vec_t v);
        start = v.start; base_addr = v.base; num_words = v.k;
`ifdef FEEDER_STALL_EN
        stall = v.stall;
`endif
        #1;
        cmp($sformatf("%s[%0d].csb", nm, idx), {31'd0, sram_csb}, {31'd0, v.e_csb});
        if (!v.e_csb) cmp($sformatf("%s[%0d].raddr", nm, idx), {22'd0, sram_raddr}, {22'd0, v.e_addr});
        cmp($sformatf("%s[%0d].valid", nm, idx), {28'd0, lane_valid}, {28'd0, v.e_v});
        cmp($sformatf("%s[%0d].data", nm, idx), lane_data, v.e_d);
        cmp($sformatf("%s[%0d].busy", nm, idx), {31'd0, busy}, {31'd0, v.e_busy});
        cmp($sformatf("%s[%0d].done", nm, idx), {31'd0, done}, {31'd0, v.e_done});
        $display("[TB] %s[%0d] csb=%b raddr=%0d valid=%b data=%h busy=%b done=%b",
                 nm, idx, sram_csb, sram_raddr, lane_valid, lane_data, busy, done);
        @(posedge clk); #1;
    endtask

    task automatic check_idle_zero(input string nm);
        cmp({nm, ".csb"}, {31'd0, sram_csb}, 32'd1);
        cmp({nm, ".raddr"}, {22'd0, sram_raddr}, 32'd0);
        cmp({nm, ".valid"}, {28'd0, lane_valid}, 32'd0);
        cmp({nm, ".data"}, lane_data, 32'd0);
        cmp({nm, ".busy"}, {31'd0, busy}, 32'd0);
        cmp({nm, ".done"}, {31'd0, done}, 32'd0);
    endtask

    vec_t tbl [22];
    vec_t neg [8];
    vec_t frs [9];
`ifdef FEEDER_STALL_EN
    vec_t stl [12];
`endif

    initial begin
        int d0;

        // K=1 base=5, then back-to-back K=4 base=0 with an ignored start, then K=0.
        tbl[0]  = idl(1'b1, 5, 1);
        tbl[1]  = ex(1'b0, 5, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        tbl[2]  = ex(1'b1, 0, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        tbl[3]  = ex(1'b1, 0, 4'h1, 32'h0000_0001, 1'b1, 1'b0);
        tbl[4]  = ex(1'b1, 0, 4'h2, 32'h0000_0200, 1'b1, 1'b0);
        tbl[5]  = ex(1'b1, 0, 4'h4, 32'h0003_0000, 1'b1, 1'b0);
        tbl[6]  = ex(1'b1, 0, 4'h8, 32'h0400_0000, 1'b1, 1'b0);
        tbl[7]  = ex(1'b1, 0, 4'h0, 32'h0000_0000, 1'b0, 1'b1);
        tbl[8]  = idl(1'b1, 0, 4);
        tbl[9]  = ex(1'b0, 0, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        tbl[10] = ex(1'b0, 1, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        tbl[11] = mk(1'b1, 64, 4, 1'b0, 1'b0, 2, 4'h1, 32'h0000_0001, 1'b1, 1'b0);
        tbl[12] = ex(1'b0, 3, 4'h3, 32'h0000_0102, 1'b1, 1'b0);
        tbl[13] = ex(1'b1, 0, 4'h7, 32'h0001_0203, 1'b1, 1'b0);
        tbl[14] = ex(1'b1, 0, 4'hF, 32'h0102_0304, 1'b1, 1'b0);
        tbl[15] = ex(1'b1, 0, 4'hE, 32'h0203_0400, 1'b1, 1'b0);
        tbl[16] = ex(1'b1, 0, 4'hC, 32'h0304_0000, 1'b1, 1'b0);
        tbl[17] = ex(1'b1, 0, 4'h8, 32'h0400_0000, 1'b1, 1'b0);
        tbl[18] = ex(1'b1, 0, 4'h0, 32'h0000_0000, 1'b0, 1'b1);
        tbl[19] = idl(1'b1, 7, 0);
        tbl[20] = ex(1'b1, 0, 4'h0, 32'h0000_0000, 1'b0, 1'b1);
        tbl[21] = idl(1'b0, 0, 0);

        // Signed bytes 80 FF 7F 00 must pass bit-exact.
        neg[0] = idl(1'b1, 0, 1);
        neg[1] = ex(1'b0, 0, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        neg[2] = ex(1'b1, 0, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        neg[3] = ex(1'b1, 0, 4'h1, 32'h0000_0080, 1'b1, 1'b0);
        neg[4] = ex(1'b1, 0, 4'h2, 32'h0000_FF00, 1'b1, 1'b0);
        neg[5] = ex(1'b1, 0, 4'h4, 32'h007F_0000, 1'b1, 1'b0);
        neg[6] = ex(1'b1, 0, 4'h8, 32'h0000_0000, 1'b1, 1'b0);
        neg[7] = ex(1'b1, 0, 4'h0, 32'h0000_0000, 1'b0, 1'b1);

        // Fresh K=2 at base 200 after a mid-transfer reset.
        frs[0] = idl(1'b1, 200, 2);
        frs[1] = ex(1'b0, 200, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        frs[2] = ex(1'b0, 201, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        frs[3] = ex(1'b1, 0, 4'h1, 32'h0000_00A1, 1'b1, 1'b0);
        frs[4] = ex(1'b1, 0, 4'h3, 32'h0000_B211, 1'b1, 1'b0);
        frs[5] = ex(1'b1, 0, 4'h6, 32'h00C3_2200, 1'b1, 1'b0);
        frs[6] = ex(1'b1, 0, 4'hC, 32'hD433_0000, 1'b1, 1'b0);
        frs[7] = ex(1'b1, 0, 4'h8, 32'h4400_0000, 1'b1, 1'b0);
        frs[8] = ex(1'b1, 0, 4'h0, 32'h0000_0000, 1'b0, 1'b1);

`ifdef FEEDER_STALL_EN
        // Same K=2 transfer with stall held in cycles 2..4: everything shifts by 3.
        stl[0]  = idl(1'b1, 200, 2);
        stl[1]  = ex(1'b0, 200, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        stl[2]  = mk(1'b0, 0, 0, 1'b1, 1'b1, 0, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        stl[3]  = mk(1'b0, 0, 0, 1'b1, 1'b1, 0, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        stl[4]  = mk(1'b0, 0, 0, 1'b1, 1'b1, 0, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        stl[5]  = ex(1'b0, 201, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
        stl[6]  = ex(1'b1, 0, 4'h1, 32'h0000_00A1, 1'b1, 1'b0);
        stl[7]  = ex(1'b1, 0, 4'h3, 32'h0000_B211, 1'b1, 1'b0);
        stl[8]  = ex(1'b1, 0, 4'h6, 32'h00C3_2200, 1'b1, 1'b0);
        stl[9]  = ex(1'b1, 0, 4'hC, 32'hD433_0000, 1'b1, 1'b0);
        stl[10] = ex(1'b1, 0, 4'h8, 32'h4400_0000, 1'b1, 1'b0);
        stl[11] = ex(1'b1, 0, 4'h0, 32'h0000_0000, 1'b0, 1'b1);
`endif

        for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
        mem[5] = 32'h0102_0304;
        for (int j = 0; j < 4; j++) mem[j] = {4{8'(j + 1)}};
        for (int j = 0; j < 8; j++) mem[100 + j] = 32'hDEAD_0000 + 32'(j);
        mem[200] = 32'hA1B2_C3D4;
        mem[201] = 32'h1122_3344;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
`ifdef FEEDER_STALL_EN
        stall = 1'b0;
`endif
        @(posedge clk); #1;
        check_idle_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 22; r++) apply_vec("tbl", r, tbl[r]);
        cmp("no_addr_ge_64", 32'(hi_addr_cnt), 32'd0);

        mem[0] = 32'h80FF_7F00;
        for (int r = 0; r < 8; r++) apply_vec("neg", r, neg[r]);

        // K=8 from base 100, reset asserted during cycle 4.
        start = 1'b1; base_addr = 10'd100; num_words = 8'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        cmp("midrst.pre_valid", {28'd0, lane_valid}, 32'h3);
        cmp("midrst.pre_data", lane_data, 32'h0000_ADDE);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check_idle_zero("midrst.async");
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_zero("midrst.after");
        cmp("midrst.no_done", 32'(done_cnt), 32'(d0));

        for (int r = 0; r < 9; r++) apply_vec("fresh", r, frs[r]);

`ifdef FEEDER_STALL_EN
        for (int r = 0; r < 12; r++) apply_vec("stall", r, stl[r]);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
